// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC0/VC1 pop arbiter: FSM encoding and default word layout.
package vc_pop_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_PAUSE  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 6;
   localparam int DEF_DEST_BIT   = 4;
   localparam int DEF_STARVE_MAX = 4;
   localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/vc_route_stage.sv
// Two-stage pop -> push pipeline: remembers which VC was popped, captures its read data
// one cycle later, then pushes the word to D0 or D1 according to its destination bit.
module vc_route_stage
   import vc_pop_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEST_BIT   = DEF_DEST_BIT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  pop_vc0,
   input  logic                  pop_vc1,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic                  busy
);

   logic                  s1_valid;
   logic                  s1_src;
   logic                  s2_valid;
   logic [DATA_WIDTH-1:0] s2_data;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         s1_valid <= 1'b0;
         s1_src   <= 1'b0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s1_valid <= pop_vc0 | pop_vc1;
         s1_src   <= pop_vc1;
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_data <= s1_src ? vc1_data : vc0_data;
      end
   end

   // Flush also masks the push of the word sitting in stage 2 during the same cycle.
   assign d0_push = s2_valid && !flush && !s2_data[DEST_BIT];
   assign d1_push = s2_valid && !flush &&  s2_data[DEST_BIT];
   assign d_data  = s2_data;
   assign busy    = s1_valid | s2_valid;

endmodule

// File: rtl/vc_pop_arbiter.sv
// Read-side engine for the VC0/VC1 FIFOs: strict VC0 priority with a starvation limit,
// back-pressure aware pop issue, destination routing and per-destination delivery counters.
module vc_pop_arbiter
   import vc_pop_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEST_BIT   = DEF_DEST_BIT,
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic [CNT_WIDTH-1:0]  cnt_d0,
   output logic [CNT_WIDTH-1:0]  cnt_d1,
   output logic                  idle
);

   localparam int            SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] starve_cnt;
   logic          any_af;
   logic          force_vc1;
   logic          in_flight;

   assign any_af    = d0_almost_full | d1_almost_full;
   assign force_vc1 = (starve_cnt == STARVE_LIM) && !vc1_empty;

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!init) begin
         state_nxt = ST_INIT;
      end else begin
         case (state)
            ST_INIT:   state_nxt = ST_IDLE;
            ST_IDLE:   if ((!vc0_empty || !vc1_empty) && !any_af) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
               if (any_af)
                  state_nxt = ST_PAUSE;
               else if (vc0_empty && vc1_empty && !in_flight)
                  state_nxt = ST_IDLE;
            end
            ST_PAUSE:  if (!any_af) state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_INIT;
         endcase
      end
   end

   // Back-pressure is checked combinationally so pops stop in the very cycle almost_full rises.
   always_comb begin
      vc0_pop = 1'b0;
      vc1_pop = 1'b0;
      if (state == ST_ACTIVE && init && !any_af) begin
         vc0_pop = !vc0_empty && !force_vc1;
         vc1_pop = !vc1_empty && (vc0_empty || force_vc1);
      end
      idle = (state == ST_IDLE) || (state == ST_INIT && !in_flight);
   end

   always_ff @(posedge clk) begin
      if (reset || !init)
         starve_cnt <= '0;
      else if (vc1_pop || vc1_empty)
         starve_cnt <= '0;
      else if (vc0_pop && starve_cnt != STARVE_LIM)
         starve_cnt <= starve_cnt + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || !init) begin
         cnt_d0 <= '0;
         cnt_d1 <= '0;
      end else begin
         if (d0_push) cnt_d0 <= cnt_d0 + CNT_WIDTH'(1);
         if (d1_push) cnt_d1 <= cnt_d1 + CNT_WIDTH'(1);
      end
   end

   vc_route_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEST_BIT   (DEST_BIT)
   ) u_route (
      .clk      (clk),
      .reset    (reset),
      .flush    (!init),
      .pop_vc0  (vc0_pop),
      .pop_vc1  (vc1_pop),
      .vc0_data (vc0_data),
      .vc1_data (vc1_data),
      .d0_push  (d0_push),
      .d1_push  (d1_push),
      .d_data   (d_data),
      .busy     (in_flight)
   );

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: behavioural VC FIFOs feed the DUT, a negedge monitor
// logs every grant and push, and hand-computed expectations are checked against the logs.
module tb_vc_pop_arbiter;
   import vc_pop_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset, init;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_data = '0, vc1_data = '0;
   logic       vc0_pop, vc1_pop;
   logic       d0_almost_full, d1_almost_full;
   logic       d0_push, d1_push;
   logic [5:0] d_data;
   logic [7:0] cnt_d0, cnt_d1;
   logic       idle;

   int vectors = 0;
   int miscompares = 0;

   logic [5:0] vc0_mem [0:255];
   logic [5:0] vc1_mem [0:255];
   int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

   int         cycle = 0;
   int         dual_pop = 0;
   bit         grants [$];
   int         pop_cyc [$];
   logic [5:0] push_data [$];
   bit         push_dest [$];
   int         push_cyc [$];

   vc_pop_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_data       (vc0_data),
      .vc1_data       (vc1_data),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .d0_push        (d0_push),
      .d1_push        (d1_push),
      .d_data         (d_data),
      .cnt_d0         (cnt_d0),
      .cnt_d1         (cnt_d1),
      .idle           (idle)
   );

   always #5 clk = ~clk;

   assign vc0_empty = (wr0 == rd0);
   assign vc1_empty = (wr1 == rd1);

   // Registered-read FIFO models: data appears the cycle after the pop.
   always @(posedge clk) begin
      if (vc0_pop) begin
         vc0_data <= vc0_mem[rd0];
         rd0 <= rd0 + 1;
      end
      if (vc1_pop) begin
         vc1_data <= vc1_mem[rd1];
         rd1 <= rd1 + 1;
      end
   end

   always @(negedge clk) begin
      cycle = cycle + 1;
      if (vc0_pop && vc1_pop) dual_pop = dual_pop + 1;
      if (vc0_pop || vc1_pop) begin
         grants.push_back(vc1_pop);
         pop_cyc.push_back(cycle);
      end
      if (d0_push || d1_push) begin
         push_data.push_back(d_data);
         push_dest.push_back(d1_push);
         push_cyc.push_back(cycle);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic i, input logic af0, input logic af1);
      @(posedge clk);
      #1;
      reset          = r;
      init           = i;
      d0_almost_full = af0;
      d1_almost_full = af1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) sample();
   endtask

   task automatic load_vc0(input logic [5:0] w);
      vc0_mem[wr0] = w;
      wr0++;
   endtask

   task automatic load_vc1(input logic [5:0] w);
      vc1_mem[wr1] = w;
      wr1++;
   endtask

   task automatic wait_pops(input int base, input int n, input string tag);
      int k = 0;
      while (grants.size() - base < n && k < 200) begin
         sample();
         k++;
      end
      checkOutput(tag, grants.size() - base, n);
   endtask

   initial begin
      int         gb, pb;
      logic [14:0] seq;
      logic [5:0]  exp_word [15];

      reset = 1'b1; init = 1'b0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      repeat (2) @(posedge clk);
      sample();
      checkOutput("reset vc0_pop", vc0_pop, 0);
      checkOutput("reset vc1_pop", vc1_pop, 0);
      checkOutput("reset pushes", {d0_push, d1_push}, 0);
      checkOutput("reset d_data", d_data, 0);
      checkOutput("reset idle", idle, 1);

      // Running with both VCs empty: nothing moves.
      applyStimulus(0, 1, 0, 0);
      idle_cycles(4);
      checkOutput("empty idle", idle, 1);
      checkOutput("empty pops", grants.size(), 0);
      checkOutput("empty cnt_d0", cnt_d0, 0);
      checkOutput("empty cnt_d1", cnt_d1, 0);

      // Three VC0 words; 0x25 has bit 4 clear, so it goes to D0.
      gb = grants.size(); pb = push_data.size();
      @(posedge clk); #1;
      load_vc0(6'h05); load_vc0(6'h15); load_vc0(6'h25);
      idle_cycles(10);
      checkOutput("t2 pops", grants.size() - gb, 3);
      checkOutput("t2 pushes", push_data.size() - pb, 3);
      checkOutput("t2 latency", push_cyc[pb] - pop_cyc[gb], 2);
      checkOutput("t2 word0", {26'd0, push_dest[pb], push_data[pb]}, {26'd0, 1'b0, 6'h05});
      checkOutput("t2 word1", {26'd0, push_dest[pb+1], push_data[pb+1]}, {26'd0, 1'b1, 6'h15});
      checkOutput("t2 word2", {26'd0, push_dest[pb+2], push_data[pb+2]}, {26'd0, 1'b0, 6'h25});
      checkOutput("t2 cnt_d0", cnt_d0, 2);
      checkOutput("t2 cnt_d1", cnt_d1, 1);
      checkOutput("t2 idle", idle, 1);

      // Both VCs loaded: VC0 x4 then a forced VC1 grant, repeating.
      gb = grants.size(); pb = push_data.size();
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) load_vc0(6'(i));
      for (int i = 0; i < 3; i++) load_vc1(6'h30 + 6'(i));
      for (int i = 0; i < 15; i++)
         exp_word[i] = ((i % 5) == 4) ? 6'h30 + 6'(i / 5) : 6'((i / 5) * 4 + (i % 5));
      idle_cycles(24);
      checkOutput("t3 pops", grants.size() - gb, 15);
      seq = '0;
      for (int i = 0; i < 15; i++) seq = {seq[13:0], grants[gb+i]};
      checkOutput("t3 grant pattern", seq, 15'b000010000100001);
      checkOutput("t3 dual pop", dual_pop, 0);
      for (int i = 0; i < 15; i++)
         checkOutput($sformatf("t3 push%0d", i), push_data[pb+i], exp_word[i]);
      checkOutput("t3 cnt_d0", cnt_d0, 14);
      checkOutput("t3 cnt_d1", cnt_d1, 4);

      // d1_almost_full rises after three pops; the two words still in flight complete.
      gb = grants.size(); pb = push_data.size();
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) load_vc0(6'h10 + 6'(i));
      wait_pops(gb, 3, "t4 pop wait");
      applyStimulus(0, 1, 0, 1);
      idle_cycles(5);
      checkOutput("t4 pops held", grants.size() - gb, 3);
      checkOutput("t4 inflight pushes", push_data.size() - pb, 3);
      checkOutput("t4 state", 32'(dut.state), 32'(ST_PAUSE));
      checkOutput("t4 idle", idle, 0);
      checkOutput("t4 cnt_d1 paused", cnt_d1, 7);
      applyStimulus(0, 1, 0, 0);
      sample();
      checkOutput("t4 no pop on release", vc0_pop, 0);
      sample();
      checkOutput("t4 resume pop", vc0_pop, 1);
      idle_cycles(12);
      checkOutput("t4 pushes", push_data.size() - pb, 8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("t4 push%0d", i), push_data[pb+i], 6'h10 + 6'(i));
      checkOutput("t4 cnt_d1", cnt_d1, 12);

      // init drops with two words in flight: both are flushed.
      gb = grants.size(); pb = push_data.size();
      @(posedge clk); #1;
      for (int i = 1; i <= 6; i++) load_vc0(6'(i));
      wait_pops(gb, 2, "t5 pop wait");
      applyStimulus(0, 0, 0, 0);
      idle_cycles(4);
      checkOutput("t5 flushed pushes", push_data.size() - pb, 0);
      checkOutput("t5 cnt_d0", cnt_d0, 0);
      checkOutput("t5 cnt_d1", cnt_d1, 0);
      checkOutput("t5 state", 32'(dut.state), 32'(ST_INIT));
      checkOutput("t5 idle", idle, 1);
      applyStimulus(0, 1, 0, 0);
      idle_cycles(12);
      checkOutput("t5 pushes after init", push_data.size() - pb, 4);
      checkOutput("t5 first word", {26'd0, push_dest[pb], push_data[pb]}, {26'd0, 1'b0, 6'h03});
      checkOutput("t5 cnt_d0 after", cnt_d0, 4);

      // reset mid-burst.
      gb = grants.size();
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) load_vc1(6'h20 + 6'(i));
      wait_pops(gb, 2, "t6 pop wait");
      applyStimulus(1, 1, 0, 0);
      @(posedge clk);
      sample();
      checkOutput("t6 pops", {vc0_pop, vc1_pop}, 0);
      checkOutput("t6 pushes", {d0_push, d1_push}, 0);
      checkOutput("t6 d_data", d_data, 0);
      checkOutput("t6 cnt_d0", cnt_d0, 0);
      checkOutput("t6 cnt_d1", cnt_d1, 0);
      checkOutput("t6 idle", idle, 1);
      checkOutput("t6 state", 32'(dut.state), 32'(ST_INIT));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
